// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared types for the matrix datapath (stream loader,
//               parallel multiplier and drain stage).
//               WORD_W  - element width
//               word_t  - one matrix element
//               ld_state_t - loader FSM states
//               idx_w() - row/column index width for an n x n matrix
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        LOAD    = 1'b0,
        PRESENT = 1'b1
    } ld_state_t;

    // An index for n == 1 still needs one bit so the ports stay legal.
    function automatic int idx_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/matrix_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : matrix_index_counter
// Description : Walks (row, col) over an n x n matrix in stream order.
//               Row-major (COL_MAJOR=0): col is the fast index.
//               Column-major (COL_MAJOR=1): row is the fast index.
//               After the last element both indices wrap to 0.
// Ports       : clk, rst (sync, active-low), advance (step one element),
//               row, col (current write position),
//               last (current position is element n*n-1)
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int n         = 10,
    parameter bit COL_MAJOR = 1'b0,
    localparam int IDX_W    = idx_w(n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(n - 1);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;
    logic             w_row_end;
    logic             w_col_end;

    assign w_row_end = (r_row == c_idx_max);
    assign w_col_end = (r_col == c_idx_max);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (COL_MAJOR) begin
                if (w_row_end) begin
                    r_row <= '0;
                    r_col <= w_col_end ? '0 : r_col + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = w_row_end && w_col_end;

endmodule : matrix_index_counter
`default_nettype wire

// File: rtl/matrix_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_stream_loader
// Description : Collects n*n 32-bit elements from a serial stb/ack stream
//               into an n x n register array, then presents the whole
//               matrix on a stb/ack matrix port. No element is accepted
//               while the matrix is presented.
// Ports       : clk, rst (sync, active-low)
//               input_data / input_data_stb / input_data_ack - element port
//               output_z / output_z_stb / output_z_ack        - matrix port
//               load_count - elements accepted in the current fill
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int n         = 10,
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  word_t      input_data,
    input  logic       input_data_stb,
    output logic       input_data_ack,
    output word_t      output_z [n-1:0][n-1:0],
    output logic       output_z_stb,
    input  logic       output_z_ack,
    output logic [7:0] load_count
);

    localparam int IDX_W = idx_w(n);

    ld_state_t        r_state;
    logic             r_ack;
    logic             r_stb;
    logic [7:0]       r_count;
    word_t            r_mat [n-1:0][n-1:0];

    logic [IDX_W-1:0] w_row;
    logic [IDX_W-1:0] w_col;
    logic             w_last;
    logic             w_elem_xfer;
    logic             w_mat_xfer;

    // r_ack is only ever high in LOAD and r_stb only in PRESENT, so the
    // handshakes alone qualify both transfers.
    assign w_elem_xfer = input_data_stb && r_ack;
    assign w_mat_xfer  = output_z_ack && r_stb;

    matrix_index_counter #(
        .n         (n),
        .COL_MAJOR (COL_MAJOR)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .advance (w_elem_xfer),
        .row     (w_row),
        .col     (w_col),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= LOAD;
            r_ack   <= 1'b1;
            r_stb   <= 1'b0;
            r_count <= 8'd0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_elem_xfer) begin
                        if (w_last) begin
                            r_state <= PRESENT;
                            r_ack   <= 1'b0;
                            r_stb   <= 1'b1;
                            r_count <= 8'd0;
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                end
                PRESENT: begin
                    if (w_mat_xfer) begin
                        r_state <= LOAD;
                        r_ack   <= 1'b1;
                        r_stb   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_ack   <= 1'b1;
                    r_stb   <= 1'b0;
                    r_count <= 8'd0;
                end
            endcase
        end
    end

    // Storage keeps the previous matrix during the next fill; each cell is
    // replaced only when its new element arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) begin
                    r_mat[r][c] <= '0;
                end
            end
        end else if (w_elem_xfer) begin
            r_mat[w_row][w_col] <= input_data;
        end
    end

    assign output_z       = r_mat;
    assign output_z_stb   = r_stb;
    assign input_data_ack = r_ack;
    assign load_count     = r_count;

endmodule : matrix_stream_loader
`default_nettype wire

// File: tb/tb_matrix_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_stream_loader
// Description : Drives a row-major and a column-major n=3 loader from the
//               same stream, plus an n=1 loader. A stream-order model
//               (element k lands at [k/n][k%n] or [k%n][k/n]) tracks the
//               expected matrix, handshakes and load count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_stream_loader;
    import matrix_pkg::*;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    word_t      input_data;
    logic       input_data_stb;
    logic       out_ack;

    logic       ack_a, ack_b, stb_a, stb_b;
    logic [7:0] cnt_a, cnt_b;
    word_t      z_a [N-1:0][N-1:0];
    word_t      z_b [N-1:0][N-1:0];

    word_t      data1;
    logic       stb1, oack1, ack1, zstb1;
    logic [7:0] cnt1;
    word_t      z1 [0:0][0:0];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    word_t exp_a [N][N];
    word_t exp_b [N][N];
    int    mdl_k;
    bit    mdl_pres;

    always #5 clk = ~clk;

    matrix_stream_loader #(.n(N), .COL_MAJOR(1'b0)) u_row (
        .clk(clk), .rst(rst),
        .input_data(input_data), .input_data_stb(input_data_stb),
        .input_data_ack(ack_a),
        .output_z(z_a), .output_z_stb(stb_a), .output_z_ack(out_ack),
        .load_count(cnt_a)
    );

    matrix_stream_loader #(.n(N), .COL_MAJOR(1'b1)) u_col (
        .clk(clk), .rst(rst),
        .input_data(input_data), .input_data_stb(input_data_stb),
        .input_data_ack(ack_b),
        .output_z(z_b), .output_z_stb(stb_b), .output_z_ack(out_ack),
        .load_count(cnt_b)
    );

    matrix_stream_loader #(.n(1), .COL_MAJOR(1'b0)) u_one (
        .clk(clk), .rst(rst),
        .input_data(data1), .input_data_stb(stb1),
        .input_data_ack(ack1),
        .output_z(z1), .output_z_stb(zstb1), .output_z_ack(oack1),
        .load_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                exp_a[r][c] = '0;
                exp_b[r][c] = '0;
            end
        mdl_k    = 0;
        mdl_pres = 0;
    endtask

    // One clock edge; the model decides from the inputs it applied.
    task automatic cycle();
        bit    xfer, mxfer;
        word_t d;
        xfer  = input_data_stb && !mdl_pres;
        mxfer = out_ack && mdl_pres;
        d     = input_data;
        @(posedge clk);
        #1;
        if (!rst) begin
            model_clear();
        end else if (xfer) begin
            exp_a[mdl_k / N][mdl_k % N] = d;
            exp_b[mdl_k % N][mdl_k / N] = d;
            mdl_k++;
            if (mdl_k == N * N) begin
                mdl_k    = 0;
                mdl_pres = 1;
            end
        end else if (mxfer) begin
            mdl_pres = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ack_a"}, ack_a, !mdl_pres);
        chk({tag, ".ack_b"}, ack_b, !mdl_pres);
        chk({tag, ".stb_a"}, stb_a, mdl_pres);
        chk({tag, ".stb_b"}, stb_b, mdl_pres);
        chk({tag, ".cnt_a"}, cnt_a, mdl_k);
        chk({tag, ".cnt_b"}, cnt_b, mdl_k);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                chk($sformatf("%s.za[%0d][%0d]", tag, r, c), z_a[r][c], exp_a[r][c]);
                chk($sformatf("%s.zb[%0d][%0d]", tag, r, c), z_b[r][c], exp_b[r][c]);
            end
    endtask

    initial begin
        int guard;
        rst = 1'b0; input_data = '0; input_data_stb = 1'b0; out_ack = 1'b0;
        data1 = '0; stb1 = 1'b0; oack1 = 1'b0;
        model_clear();

        // Reset
        repeat (2) cycle();
        check_all("reset");
        rst = 1'b1;

        // Back-to-back fill 1..9, consumer not acking
        input_data_stb = 1'b1;
        for (int i = 1; i <= N * N; i++) begin
            input_data = word_t'(i);
            check_all($sformatf("fill%0d", i));
            cycle();
        end
        check_all("present");
        chk("row.z00", z_a[0][0], 32'd1);
        chk("row.z02", z_a[0][2], 32'd3);
        chk("row.z22", z_a[2][2], 32'd9);
        chk("col.z10", z_b[1][0], 32'd2);
        chk("col.z01", z_b[0][1], 32'd4);
        chk("col.z22", z_b[2][2], 32'd9);

        // Stall while presented; producer keeps pushing 99
        input_data = 32'd99;
        repeat (20) begin
            cycle();
            check_all("stall");
        end
        out_ack = 1'b1;
        cycle();
        out_ack = 1'b0;
        check_all("released");
        cycle();
        check_all("first99");
        chk("row.z00_99", z_a[0][0], 32'd99);
        chk("col.z00_99", z_b[0][0], 32'd99);

        // Gapped random stream, consumer ack toggling (ignored in LOAD)
        guard = 0;
        while (!mdl_pres && guard < 200) begin
            input_data_stb = (guard % 2 == 0) ? 1'($urandom) : 1'b0;
            input_data     = $urandom;
            out_ack        = 1'($urandom);
            cycle();
            check_all("gap");
            guard++;
        end
        chk("gap.done", mdl_pres, 1'b1);
        input_data_stb = 1'b0;
        out_ack = 1'b1;
        cycle();
        out_ack = 1'b0;
        check_all("gap.ack");

        // Reset mid-fill, then refill 10..18
        input_data_stb = 1'b1;
        repeat (5) begin
            input_data = $urandom;
            cycle();
            check_all("partial");
        end
        input_data_stb = 1'b0;
        rst = 1'b0;
        cycle();
        check_all("midreset");
        rst = 1'b1;
        input_data_stb = 1'b1;
        for (int i = 10; i <= 18; i++) begin
            input_data = word_t'(i);
            check_all($sformatf("refill%0d", i));
            cycle();
        end
        input_data_stb = 1'b0;
        check_all("refilled");
        chk("refill.z00", z_a[0][0], 32'd10);
        out_ack = 1'b1;
        cycle();
        out_ack = 1'b0;
        check_all("refill.ack");

        // n = 1 instance
        data1 = 32'hDEADBEEF;
        stb1  = 1'b1;
        chk("one.ack0", ack1, 1'b1);
        chk("one.stb0", zstb1, 1'b0);
        @(posedge clk); #1;
        stb1 = 1'b0;
        chk("one.stb1", zstb1, 1'b1);
        chk("one.z", z1[0][0], 32'hDEADBEEF);
        chk("one.ack1", ack1, 1'b0);
        chk("one.cnt", cnt1, 8'd0);
        @(posedge clk); #1;
        chk("one.hold", zstb1, 1'b1);
        oack1 = 1'b1;
        @(posedge clk); #1;
        oack1 = 1'b0;
        chk("one.ack2", ack1, 1'b1);
        chk("one.stb2", zstb1, 1'b0);
        chk("one.zkeep", z1[0][0], 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_matrix_stream_loader
`default_nettype wire
